// File: rtl/vga_sync_monitor_if.sv
// vga_sync_monitor_if: sampled sync inputs and recovered timing/status outputs of the VGA sync monitor.
// VGA_SYNC_MONITOR_STATS_EN adds the err_count statistics output.
interface vga_sync_monitor_if;
  logic clock_25, vga_hs, vga_vs, video_on;
  logic [9:0] rx_x, rx_y;
  logic locked, h_err, v_err, de_err, frame_tick;
`ifdef VGA_SYNC_MONITOR_STATS_EN
  logic [15:0] err_count;
  modport master(output clock_25, vga_hs, vga_vs, video_on,
                 input rx_x, rx_y, locked, h_err, v_err, de_err, frame_tick, err_count);
  modport slave(input clock_25, vga_hs, vga_vs, video_on,
                output rx_x, rx_y, locked, h_err, v_err, de_err, frame_tick, err_count);
`else
  modport master(output clock_25, vga_hs, vga_vs, video_on,
                 input rx_x, rx_y, locked, h_err, v_err, de_err, frame_tick);
  modport slave(input clock_25, vga_hs, vga_vs, video_on,
                output rx_x, rx_y, locked, h_err, v_err, de_err, frame_tick);
`endif
endinterface

// File: rtl/vga_sync_monitor.sv
// vga_sync_monitor: recovers VGA pixel position from hs/vs, checks line/frame/pulse timing, reports lock.
// VGA_SYNC_MONITOR_STATS_EN adds a saturating err_count of cycles with any error pulse.
module vga_sync_monitor #(
  parameter int H_DISP = 640, H_SYNC_START = 656, H_SYNC = 96, H_TOTAL = 800,
  parameter int V_DISP = 480, V_SYNC_START = 490, V_SYNC = 2, V_TOTAL = 525,
  parameter int LOCK_FRAMES = 2
) (
  input logic clock_50,
  input logic reset_key,
  vga_sync_monitor_if.slave vga
);
  typedef enum logic [1:0] {SEARCH, TRACK, LOCKED} state_t;
  state_t state, state_nx;
  logic hs_d, vs_d, h_seen, v_seen, tick, hs_fall, hs_rise, vs_fall, vs_rise;
  logic x_wrap, y_wrap, h_bad, v_bad, de_bad, err;
  logic [10:0] hper, hlow, vlines, vlow;
  logic [7:0] good, good_nx, good_inc;
  function automatic logic [10:0] sat(input logic [10:0] v);
    return &v ? v : v + 11'd1;
  endfunction
  always_comb begin
    tick = vga.clock_25;
    hs_fall = hs_d & ~vga.vga_hs;
    hs_rise = ~hs_d & vga.vga_hs;
    vs_fall = vs_d & ~vga.vga_vs;
    vs_rise = ~vs_d & vga.vga_vs;
    x_wrap = vga.rx_x == 10'(H_TOTAL - 1);
    y_wrap = vga.rx_y == 10'(V_TOTAL - 1);
    h_bad = tick & (state != SEARCH) & h_seen &
            ((hs_fall & (hper != 11'(H_TOTAL - 1))) | (hs_rise & (hlow != 11'(H_SYNC))));
    v_bad = tick & (state != SEARCH) & v_seen &
            ((vs_fall & (vlines != 11'(V_TOTAL))) | (vs_rise & (vlow != 11'(V_SYNC))));
    de_bad = tick & (state == LOCKED) &
             (vga.video_on != ((vga.rx_x < 10'(H_DISP)) & (vga.rx_y < 10'(V_DISP))));
    err = h_bad | v_bad | de_bad;
    good_inc = good + 8'd1;
    state_nx = err ? SEARCH : !(tick & vs_fall) ? state : (state == SEARCH) ? TRACK :
               (state == TRACK && good_inc == 8'(LOCK_FRAMES)) ? LOCKED : state;
    good_nx = (err | !(tick & vs_fall)) ? good : (state == SEARCH) ? 8'd0 :
              (state == TRACK) ? good_inc : good;
  end
  always_ff @(posedge clock_50 or negedge reset_key) begin
    if (!reset_key) begin
      state <= SEARCH;
      good <= '0;
      hs_d <= 1'b1;
      vs_d <= 1'b1;
      h_seen <= 1'b0;
      v_seen <= 1'b0;
      hper <= '0;
      hlow <= '0;
      vlines <= '0;
      vlow <= '0;
      vga.rx_x <= '0;
      vga.rx_y <= '0;
      vga.locked <= 1'b0;
      vga.h_err <= 1'b0;
      vga.v_err <= 1'b0;
      vga.de_err <= 1'b0;
      vga.frame_tick <= 1'b0;
    end else begin
      state <= state_nx;
      good <= good_nx;
      vga.locked <= state_nx == LOCKED;
      vga.h_err <= h_bad;
      vga.v_err <= v_bad;
      vga.de_err <= de_bad;
      vga.frame_tick <= tick & vs_fall;
      if (tick) begin
        hs_d <= vga.vga_hs;
        vs_d <= vga.vga_vs;
        hper <= hs_fall ? 11'd0 : sat(hper);
        hlow <= hs_fall ? 11'd1 : ~vga.vga_hs ? sat(hlow) : hlow;
        vlines <= vs_fall ? {10'd0, hs_fall} : hs_fall ? sat(vlines) : vlines;
        vlow <= vs_fall ? {10'd0, hs_fall} : (hs_fall & ~vga.vga_vs) ? sat(vlow) : vlow;
        h_seen <= ~err & (h_seen | hs_fall);
        v_seen <= ~err & (v_seen | vs_fall);
        vga.rx_x <= hs_fall ? 10'(H_SYNC_START) : x_wrap ? 10'd0 : vga.rx_x + 10'd1;
        vga.rx_y <= vs_fall ? 10'(V_SYNC_START) : !x_wrap ? vga.rx_y : y_wrap ? 10'd0 : vga.rx_y + 10'd1;
      end
    end
  end
`ifdef VGA_SYNC_MONITOR_STATS_EN
  always_ff @(posedge clock_50 or negedge reset_key) begin
    if (!reset_key) vga.err_count <= '0;
    else if ((vga.h_err | vga.v_err | vga.de_err) & ~&vga.err_count) vga.err_count <= vga.err_count + 16'd1;
  end
`endif
endmodule

// File: tb/tb_vga_sync_monitor.sv
// tb_vga_sync_monitor: randomized sync stream with injected timing faults and resets, checked every cycle
// against a timestamp-based reference model of the monitor.
module tb_vga_sync_monitor;
  localparam int HD = 8, HSS = 10, HS = 3, HT = 16, VD = 6, VSS = 7, VS = 2, VT = 10, LF = 2;
  localparam int K_CLEAN = 0, K_LONG = 1, K_SHORTHS = 2, K_SHORTF = 3, K_WIDEVS = 4, K_DE = 5, K_RST = 6;
  logic clock_50 = 1'b0, reset_key = 1'b0;
  int vectors = 0, miscompares = 0;
  int t = 0, last_hf = 0, hf_cnt = 0, vf_base = 0, st = 0, good = 0, mx = 0, my = 0, e_cnt = 0;
  logic prev_hs, prev_vs, hseen, vseen, e_h, e_v, e_de, e_ft, pulse_any, prev_disp = 1'b0;
  vga_sync_monitor_if vga();
  vga_sync_monitor #(.H_DISP(HD), .H_SYNC_START(HSS), .H_SYNC(HS), .H_TOTAL(HT),
                     .V_DISP(VD), .V_SYNC_START(VSS), .V_SYNC(VS), .V_TOTAL(VT),
                     .LOCK_FRAMES(LF)) dut (.clock_50(clock_50), .reset_key(reset_key), .vga(vga));
  always #10 clock_50 = ~clock_50;
  function automatic int sat(input int v);
    return v > 2047 ? 2047 : v;
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d tick=%0d", tag, obs, exp, t);
    end
  endtask
  task automatic check_all();
    chk("rx_x", 32'(vga.rx_x), mx);
    chk("rx_y", 32'(vga.rx_y), my);
    chk("locked", 32'(vga.locked), 32'(st == 2));
    chk("h_err", 32'(vga.h_err), 32'(e_h));
    chk("v_err", 32'(vga.v_err), 32'(e_v));
    chk("de_err", 32'(vga.de_err), 32'(e_de));
    chk("frame_tick", 32'(vga.frame_tick), 32'(e_ft));
`ifdef VGA_SYNC_MONITOR_STATS_EN
    chk("err_count", 32'(vga.err_count), e_cnt);
`endif
  endtask
  task automatic cnt_step(input logic p);
    if (pulse_any && e_cnt < 65535) e_cnt++;
    pulse_any = p;
  endtask
  task automatic m_reset();
    prev_hs = 1'b1; prev_vs = 1'b1; hseen = 1'b0; vseen = 1'b0;
    st = 0; good = 0; mx = 0; my = 0; e_cnt = 0; pulse_any = 1'b0;
    e_h = 1'b0; e_v = 1'b0; e_de = 1'b0; e_ft = 1'b0;
  endtask
  // Spec-level model: periods and widths come from tick/hs_fall timestamps, not running counters.
  task automatic model(input logic hs, input logic vs, input logic de);
    logic hf, hr, vf, vr, hc, vc;
    hf = prev_hs & ~hs; hr = ~prev_hs & hs; vf = prev_vs & ~vs; vr = ~prev_vs & vs;
    hc = hseen && ((hf && sat(t - last_hf - 1) != HT - 1) || (hr && sat(t - last_hf) != HS));
    vc = vseen && ((vf && sat(hf_cnt - vf_base) != VT) || (vr && sat(hf_cnt - vf_base) != VS));
    e_h = st != 0 && hc;
    e_v = st != 0 && vc;
    e_de = st == 2 && de != (mx < HD && my < VD);
    e_ft = vf;
    hseen = hseen | hf;
    vseen = vseen | vf;
    if (e_h || e_v || e_de) begin
      st = 0; hseen = 1'b0; vseen = 1'b0;
    end else if (vf) begin
      if (st == 0) begin st = 1; good = 0; end
      else if (st == 1) begin good++; if (good == LF) st = 2; end
    end
    my = vf ? VSS : (mx == HT - 1) ? (my == VT - 1 ? 0 : my + 1) : my;
    mx = hf ? HSS : (mx == HT - 1 ? 0 : mx + 1);
    if (hf) last_hf = t;
    if (vf) vf_base = hf_cnt;
    hf_cnt += int'(hf);
    prev_hs = hs; prev_vs = vs;
    t++;
    cnt_step(e_h | e_v | e_de);
  endtask
  task automatic tick(input logic hs, input logic vs, input logic de);
    @(negedge clock_50);
    vga.clock_25 = 1'b1; vga.vga_hs = hs; vga.vga_vs = vs; vga.video_on = de;
    model(hs, vs, de);
    @(posedge clock_50); #1;
    check_all();
    repeat ($urandom_range(0, 2)) begin
      @(negedge clock_50);
      vga.clock_25 = 1'b0;
      e_h = 1'b0; e_v = 1'b0; e_de = 1'b0; e_ft = 1'b0;
      cnt_step(1'b0);
      @(posedge clock_50); #1;
      check_all();
    end
  endtask
  task automatic do_reset();
    #2 reset_key = 1'b0;
    #1 m_reset();
    check_all();
    @(negedge clock_50) vga.clock_25 = 1'b0;
    @(negedge clock_50) reset_key = 1'b1;
  endtask
  // Sync leads video_on by one pixel: video_on is the display window of the previously sent pixel.
  task automatic frame(input int kind);
    int vt, vsw, fl, fp, htot, hsw;
    vt = kind == K_SHORTF ? VT - 1 : VT;
    vsw = kind == K_WIDEVS ? VS + 1 : VS;
    fl = $urandom_range(0, vt - 1);
    fp = $urandom_range(0, HT - 1);
    for (int py = 0; py < vt; py++) begin
      htot = (kind == K_LONG && py == fl) ? HT + 1 : HT;
      hsw = (kind == K_SHORTHS && py == fl) ? HS - 1 : HS;
      for (int px = 0; px < htot; px++) begin
        if (kind == K_RST && py == fl && px == fp) do_reset();
        tick(!(px >= HSS && px < HSS + hsw), !(py >= VSS && py < VSS + vsw),
             prev_disp ^ (kind == K_DE && py == fl && px == fp));
        prev_disp = px < HD && py < VD;
        if (kind == K_CLEAN && st == 2) chk("rx_track", 32'(vga.rx_x), px);
      end
    end
  endtask
  initial begin
    vga.clock_25 = 1'b0; vga.vga_hs = 1'b1; vga.vga_vs = 1'b1; vga.video_on = 1'b0;
    m_reset();
    repeat (3) @(posedge clock_50);
    #1 check_all();
    @(negedge clock_50) reset_key = 1'b1;
    frame(K_CLEAN);
    chk("lock_after_1", 32'(vga.locked), 0);
    frame(K_CLEAN);
    chk("lock_after_2", 32'(vga.locked), 0);
    frame(K_CLEAN);
    chk("lock_after_3", 32'(vga.locked), 1);
    repeat (3) frame(K_CLEAN);
    for (int i = 0; i < 30; i++) begin
      frame($urandom_range(K_LONG, K_RST));
      repeat (4) frame(K_CLEAN);
      chk("relock", 32'(vga.locked), 1);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
